// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the regfile write port.
// ALU results take priority; load returns are buffered in a small FIFO and
// drained when the ALU slot is free. An idle cycle with no buffered loads lets
// an incoming load go straight to the write port. A starvation counter forces
// one ALU stall cycle when buffered loads have waited too long. A pending-load
// scoreboard tells decode which registers still wait on a load.
module regfile_wb_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_stall,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_addr,
    input  logic [ADDR_W-1:0] r_addr1,
    input  logic [ADDR_W-1:0] r_addr2,
    output logic              busy1,
    output logic              busy2,
    output logic              w_enable,
    output logic [ADDR_W-1:0] w_addr1,
    output logic [DATA_W-1:0] w_data1
);

    localparam int NREG     = 1 << ADDR_W;
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = $clog2(DEPTH) + 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int ENTRY_W  = ADDR_W + DATA_W;

    logic [ENTRY_W-1:0]  fifo_mem [DEPTH];
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [CNT_W-1:0]    count;
    logic [NREG-1:0]     pending;
    logic [STARVE_W-1:0] starve_cnt;
    logic                w_is_load;

    logic                fifo_empty;
    logic                ld_accept;
    logic                do_pop;
    logic                do_push;
    logic                sel_valid;
    logic                sel_is_load;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic [ADDR_W-1:0]   head_addr;
    logic [DATA_W-1:0]   head_data;
    logic                starve_inc;
    logic                starve_hit;
    logic [NREG-1:0]     pending_next;

    // Ready depends only on the registered fill level, so a full FIFO refuses even while popping.
    assign ld_ready   = rst_n && (count != CNT_W'(DEPTH));
    assign fifo_empty = (count == '0);
    assign ld_accept  = ld_valid && ld_ready;
    assign head_addr  = fifo_mem[rd_ptr][ENTRY_W-1:DATA_W];
    assign head_data  = fifo_mem[rd_ptr][DATA_W-1:0];

    assign busy1 = (r_addr1 != '0) && pending[r_addr1];
    assign busy2 = (r_addr2 != '0) && pending[r_addr2];

    // Choose the write source for the next cycle: ALU, then FIFO head, then a bypassed load.
    always_comb begin
        do_pop      = 1'b0;
        do_push     = 1'b0;
        sel_valid   = 1'b0;
        sel_is_load = 1'b0;
        sel_addr    = alu_addr;
        sel_data    = alu_data;
        if (alu_valid) begin
            sel_valid = 1'b1;
            do_push   = ld_accept;
        end else if (!fifo_empty) begin
            sel_valid   = 1'b1;
            sel_is_load = 1'b1;
            sel_addr    = head_addr;
            sel_data    = head_data;
            do_pop      = 1'b1;
            do_push     = ld_accept;
        end else if (ld_accept) begin
            sel_valid   = 1'b1;
            sel_is_load = 1'b1;
            sel_addr    = ld_addr;
            sel_data    = ld_data;
        end
    end

    // Starvation: count cycles where buffered loads are blocked by the ALU.
    always_comb begin
        starve_inc = !fifo_empty && alu_valid;
        starve_hit = starve_inc && (starve_cnt == STARVE_W'(STARVE_LIMIT - 1));
    end

    // Scoreboard update: a completed load write clears its bit, a new issue sets one and wins ties.
    always_comb begin
        pending_next = pending;
        if (w_enable && w_is_load) begin
            pending_next[w_addr1] = 1'b0;
        end
        if (sb_set && (sb_addr != '0)) begin
            pending_next[sb_addr] = 1'b1;
        end
    end

    // FIFO storage is data-only and needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr] <= {ld_addr, ld_data};
        end
    end

    // All control state, the output register and the scoreboard.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            pending    <= '0;
            starve_cnt <= '0;
            alu_stall  <= 1'b0;
            w_enable   <= 1'b0;
            w_addr1    <= '0;
            w_data1    <= '0;
            w_is_load  <= 1'b0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            pending <= pending_next;

            if (starve_hit) begin
                starve_cnt <= '0;
                alu_stall  <= 1'b1;
            end else if (starve_inc) begin
                starve_cnt <= starve_cnt + STARVE_W'(1);
                alu_stall  <= 1'b0;
            end else begin
                starve_cnt <= '0;
                alu_stall  <= 1'b0;
            end

            if (sel_valid) begin
                w_enable  <= (sel_addr != '0);
                w_is_load <= sel_is_load;
                w_addr1   <= sel_addr;
                w_data1   <= sel_data;
            end else begin
                w_enable  <= 1'b0;
                w_is_load <= 1'b0;
            end
        end
    end

    // Upstream must keep the ALU quiet during a forced stall cycle.
    a_no_alu_during_stall : assert property (@(posedge clk) disable iff (!rst_n) !(alu_valid && alu_stall));

endmodule
